// File: rtl/dmem_lsu_param.sv
// Word-organised little-endian data RAM behind a valid/ready port with registered
// responses, range checking and optional two-cycle splitting of misaligned accesses.
module dmem_lsu_param #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic [1:0]  mem_mode_i,
  input  logic        mem_unsigned_i,
  input  logic        st_en_i,
  input  logic [31:0] st_data_i,
  output logic        rsp_valid_o,
  output logic [31:0] ld_data_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t state;

  logic [31:0] mem [DEPTH_WORDS];

  // Latched split request: high-word write payload and low-word read data
  logic [AW-1:0] lat_widx_nx;
  logic [1:0]    lat_off;
  logic [1:0]    lat_mode;
  logic          lat_uns;
  logic          lat_st;
  logic [31:0]   lat_hi_data;
  logic [3:0]    lat_hi_mask;
  logic [31:0]   lat_w0;

  logic [1:0]    off;
  logic [31:0]   rel;
  logic [31:0]   widx32;
  logic [AW-1:0] widx;
  logic [3:0]    lane_mask;
  logic [7:0]    mask8;
  logic [63:0]   data64;
  logic          misal;
  logic          err_c;
  logic          accept;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;
  logic [31:0]   rd_lo;
  logic [31:0]   rd_hi;

  function automatic logic [31:0] extend(input logic [31:0] raw,
                                         input logic [1:0]  mode,
                                         input logic        uns);
    logic [31:0] res;
    case (mode)
      2'b00:   res = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   res = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Request decode: word index, lane placement, misalignment and error detection
  always_comb begin
    off       = addr_i[1:0];
    rel       = addr_i - BASE_ADDR;
    widx32    = rel >> 2;
    widx      = widx32[AW-1:0];
    lane_mask = 4'b0000;
    misal     = 1'b0;
    case (mem_mode_i)
      2'b00: lane_mask = 4'b0001;
      2'b01: begin
        lane_mask = 4'b0011;
        misal     = (off == 2'd3);
      end
      2'b10: begin
        lane_mask = 4'b1111;
        misal     = (off != 2'd0);
      end
      default: lane_mask = 4'b0000;
    endcase
    mask8  = 8'(lane_mask) << off;
    data64 = 64'(st_data_i) << {off, 3'b000};
    err_c  = (mem_mode_i == 2'b11)
          || (addr_i < BASE_ADDR)
          || (widx32 >= 32'(DEPTH_WORDS))
          || (misal && (!MISALIGN_SPLIT || (widx32 + 32'd1 >= 32'(DEPTH_WORDS))));
    accept = req_valid_i && req_ready_o;
  end

  // Single RAM write port: low word at accept, high word in SECOND
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = widx;
    wr_data = data64[31:0];
    wr_mask = mask8[3:0];
    if (state == SECOND) begin
      wr_en   = lat_st;
      wr_idx  = lat_widx_nx;
      wr_data = lat_hi_data;
      wr_mask = lat_hi_mask;
    end else begin
      wr_en = accept && !err_c && st_en_i;
    end
  end

  always_comb begin
    rd_lo = mem[widx];
    rd_hi = mem[lat_widx_nx];
  end

  // RAM array: contents are not reset
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      ld_data_o   <= 32'h0;
      err_o       <= 1'b0;
      lat_widx_nx <= '0;
      lat_off     <= 2'd0;
      lat_mode    <= 2'd0;
      lat_uns     <= 1'b0;
      lat_st      <= 1'b0;
      lat_hi_data <= 32'h0;
      lat_hi_mask <= 4'h0;
      lat_w0      <= 32'h0;
    end else begin
      rsp_valid_o <= 1'b0;
      err_o       <= 1'b0;
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (accept) begin
            if (err_c) begin
              rsp_valid_o <= 1'b1;
              err_o       <= 1'b1;
              ld_data_o   <= 32'h0;
            end else if (misal) begin
              state       <= SECOND;
              req_ready_o <= 1'b0;
              lat_widx_nx <= widx + AW'(1);
              lat_off     <= off;
              lat_mode    <= mem_mode_i;
              lat_uns     <= mem_unsigned_i;
              lat_st      <= st_en_i;
              lat_hi_data <= data64[63:32];
              lat_hi_mask <= mask8[7:4];
              lat_w0      <= rd_lo;
            end else begin
              rsp_valid_o <= 1'b1;
              ld_data_o   <= st_en_i ? 32'h0
                           : extend(rd_lo >> {off, 3'b000}, mem_mode_i, mem_unsigned_i);
            end
          end
        end
        SECOND: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b1;
          ld_data_o   <= lat_st ? 32'h0
                       : extend(32'({rd_hi, lat_w0} >> {lat_off, 3'b000}), lat_mode, lat_uns);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
